// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered microaddress, next-address select with
// condition test, and a small return-address stack with sticky error flags.
module micro_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned NCOND       = 4,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0,
  parameter int unsigned FETCH_ADDR  = 1
) (
  input  logic                               CLK,
  input  logic                               reset,
  input  logic                               en,
  input  logic [2:0]                         ns_op,
  input  logic [ADDR_W-1:0]                  cr,
  input  logic [ADDR_W-1:0]                  dispatch_addr,
  input  logic [NCOND-1:0]                   cond_vec,
  input  logic [$clog2(NCOND)-1:0]           cond_sel,
  input  logic                               cond_inv,
  output logic [ADDR_W-1:0]                  uaddr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               ovf,
  output logic                               unf
);

  localparam int unsigned SEL_W  = $clog2(NCOND);
  localparam int unsigned CEXT_W = 2 ** SEL_W;
  localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OpDispatch = 3'b000,
    OpFetch    = 3'b001,
    OpJump     = 3'b010,
    OpInc      = 3'b011,
    OpCbr      = 3'b100,
    OpWait     = 3'b101,
    OpCall     = 3'b110,
    OpRet      = 3'b111
  } ns_op_e;

  ns_op_e              op;
  logic [CEXT_W-1:0]   cond_ext;
  logic                c;
  logic [ADDR_W-1:0]   inc;
  logic [ADDR_W-1:0]   uaddr_q, uaddr_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                ovf_q, unf_q;
  logic                push, pop, set_ovf, set_unf;
  logic                full, empty;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];

  assign op       = ns_op_e'(ns_op);
  // Zero-extend so that selects beyond NCOND read as 0.
  assign cond_ext = CEXT_W'(cond_vec);
  assign c        = cond_ext[cond_sel] ^ cond_inv;
  assign inc      = uaddr_q + ADDR_W'(1);
  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign wr_idx   = IDX_W'(sp_q);
  assign rd_idx   = IDX_W'(sp_q - SP_W'(1));

  // Next-address select and stack control.
  always_comb begin
    uaddr_d = uaddr_q;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    unique case (op)
      OpDispatch: uaddr_d = dispatch_addr;
      OpFetch:    uaddr_d = ADDR_W'(FETCH_ADDR);
      OpJump:     uaddr_d = cr;
      OpInc:      uaddr_d = inc;
      OpCbr:      uaddr_d = c ? cr : inc;
      OpWait:     uaddr_d = c ? inc : uaddr_q;
      OpCall: begin
        uaddr_d = cr;
        // A full stack still takes the jump; the return address is lost.
        if (full) set_ovf = 1'b1;
        else      push    = 1'b1;
      end
      OpRet: begin
        if (empty) begin
          uaddr_d = ADDR_W'(FETCH_ADDR);
          set_unf = 1'b1;
        end else begin
          pop     = 1'b1;
          uaddr_d = stack_q[rd_idx];
        end
      end
      default: uaddr_d = uaddr_q;
    endcase
  end

  // Stack pointer next state.
  always_comb begin
    sp_d = sp_q;
    if (push)     sp_d = sp_q + SP_W'(1);
    else if (pop) sp_d = sp_q - SP_W'(1);
  end

  // Sequencer state with asynchronous reset; en low freezes everything.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      uaddr_q <= ADDR_W'(RESET_ADDR);
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (en) begin
      uaddr_q <= uaddr_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_q | set_ovf;
      unf_q   <= unf_q | set_unf;
    end
  end

  // Return-address storage; contents above sp are don't-care, so no reset.
  always_ff @(posedge CLK) begin
    if (en && push) stack_q[wr_idx] <= inc;
  end

  assign uaddr = uaddr_q;
  assign sp    = sp_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer at default parameters.
module tb_micro_sequencer;

  localparam logic [2:0] DISP = 3'b000, FETCH = 3'b001, JUMP = 3'b010, INC = 3'b011;
  localparam logic [2:0] CBR = 3'b100, WAIT = 3'b101, CALL = 3'b110, RET = 3'b111;

  logic       CLK;
  logic       reset;
  logic       en;
  logic [2:0] ns_op;
  logic [7:0] cr;
  logic [7:0] dispatch_addr;
  logic [3:0] cond_vec;
  logic [1:0] cond_sel;
  logic       cond_inv;
  logic [7:0] uaddr;
  logic [2:0] sp;
  logic       ovf;
  logic       unf;

  micro_sequencer dut (
    .CLK          (CLK),
    .reset        (reset),
    .en           (en),
    .ns_op        (ns_op),
    .cr           (cr),
    .dispatch_addr(dispatch_addr),
    .cond_vec     (cond_vec),
    .cond_sel     (cond_sel),
    .cond_inv     (cond_inv),
    .uaddr        (uaddr),
    .sp           (sp),
    .ovf          (ovf),
    .unf          (unf)
  );

  typedef struct {
    string      name;
    logic [7:0] ua;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Monitor: pops one expectation per presented sample and compares.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sample_without_expectation: got uaddr=%0d sp=%0d, required none", uaddr, sp);
      end else begin
        e = sb_q.pop_front();
        if ({uaddr, sp, ovf, unf} !== {e.ua, e.sp, e.ovf, e.unf}) begin
          n_err++;
          $display("FAIL %s: got uaddr=%0d sp=%0d ovf=%b unf=%b, required uaddr=%0d sp=%0d ovf=%b unf=%b",
                   e.name, uaddr, sp, ovf, unf, e.ua, e.sp, e.ovf, e.unf);
        end
      end
    end
  end

  task automatic expect_now(input string nm, input logic [7:0] ua, input logic [2:0] s,
                            input logic o, input logic u);
    exp_t e;
    e.name = nm; e.ua = ua; e.sp = s; e.ovf = o; e.unf = u;
    sb_q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  task automatic step(input logic [2:0] o, input logic [7:0] c, input string nm,
                      input logic [7:0] ua, input logic [2:0] s, input logic ov, input logic un);
    ns_op = o;
    cr    = c;
    @(posedge CLK);
    @(negedge CLK);
    expect_now(nm, ua, s, ov, un);
  endtask

  // Asynchronous reset between clock edges, checked before any edge.
  task automatic do_reset(input string nm);
    reset = 1'b0;
    #2;
    expect_now(nm, 8'd0, 3'd0, 1'b0, 1'b0);
    @(negedge CLK);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    logic [7:0] targets [5];
    targets[0] = 8'd20; targets[1] = 8'd30; targets[2] = 8'd50;
    targets[3] = 8'd60; targets[4] = 8'd70;

    reset = 1'b0; en = 1'b1; ns_op = INC; cr = '0; dispatch_addr = '0;
    cond_vec = '0; cond_sel = '0; cond_inv = 1'b0;
    #2;
    expect_now("reset_state", 8'd0, 3'd0, 1'b0, 1'b0);
    @(negedge CLK);
    reset = 1'b1;
    #1;

    // Increment and enable gating
    step(INC, 8'd0, "inc1", 8'd1, 3'd0, 1'b0, 1'b0);
    step(INC, 8'd0, "inc2", 8'd2, 3'd0, 1'b0, 1'b0);
    step(INC, 8'd0, "inc3", 8'd3, 3'd0, 1'b0, 1'b0);
    do_reset("reset_after_inc");
    step(INC, 8'd0, "en_inc1", 8'd1, 3'd0, 1'b0, 1'b0);
    en = 1'b0;
    step(CALL, 8'd99, "en0_hold", 8'd1, 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    step(INC, 8'd0, "en_inc2", 8'd2, 3'd0, 1'b0, 1'b0);

    // WAIT on MOC
    step(JUMP, 8'd5, "jump5", 8'd5, 3'd0, 1'b0, 1'b0);
    cond_vec = 4'b0000;
    for (int i = 0; i < 3; i++) step(WAIT, 8'd0, "wait_hold", 8'd5, 3'd0, 1'b0, 1'b0);
    cond_vec = 4'b0001;
    step(WAIT, 8'd0, "wait_go", 8'd6, 3'd0, 1'b0, 1'b0);
    step(JUMP, 8'd5, "jump5b", 8'd5, 3'd0, 1'b0, 1'b0);
    cond_inv = 1'b1; cond_vec = 4'b0000;
    step(WAIT, 8'd0, "wait_inv_go", 8'd6, 3'd0, 1'b0, 1'b0);
    cond_vec = 4'b0001;
    step(WAIT, 8'd0, "wait_inv_hold", 8'd6, 3'd0, 1'b0, 1'b0);
    cond_inv = 1'b0;

    // Conditional branch
    cond_sel = 2'd1; cond_vec = 4'b0010;
    step(JUMP, 8'd10, "jump10a", 8'd10, 3'd0, 1'b0, 1'b0);
    step(CBR, 8'd40, "cbr_taken", 8'd40, 3'd0, 1'b0, 1'b0);
    cond_vec = 4'b0000;
    step(JUMP, 8'd10, "jump10b", 8'd10, 3'd0, 1'b0, 1'b0);
    step(CBR, 8'd40, "cbr_not_taken", 8'd11, 3'd0, 1'b0, 1'b0);
    cond_sel = 2'd3; cond_vec = 4'b1000;
    step(JUMP, 8'd10, "jump10c", 8'd10, 3'd0, 1'b0, 1'b0);
    step(CBR, 8'd40, "cbr_sel3", 8'd40, 3'd0, 1'b0, 1'b0);
    cond_vec = 4'b0111;
    step(JUMP, 8'd10, "jump10d", 8'd10, 3'd0, 1'b0, 1'b0);
    step(CBR, 8'd40, "cbr_sel3_clear", 8'd11, 3'd0, 1'b0, 1'b0);
    cond_sel = 2'd0; cond_vec = 4'b0000;

    // Call/return stack, overflow and underflow
    do_reset("reset_before_stack");
    step(JUMP, 8'd7, "jump7", 8'd7, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(CALL, targets[i], "call", targets[i], 3'(i + 1), 1'b0, 1'b0);
    step(CALL, 8'd70, "call_ovf", 8'd70, 3'd4, 1'b1, 1'b0);
    en = 1'b0;
    step(RET, 8'd0, "en0_ret_hold", 8'd70, 3'd4, 1'b1, 1'b0);
    en = 1'b1;
    step(RET, 8'd0, "ret1", 8'd51, 3'd3, 1'b1, 1'b0);
    step(RET, 8'd0, "ret2", 8'd31, 3'd2, 1'b1, 1'b0);
    step(RET, 8'd0, "ret3", 8'd21, 3'd1, 1'b1, 1'b0);
    step(RET, 8'd0, "ret4", 8'd8,  3'd0, 1'b1, 1'b0);
    step(RET, 8'd0, "ret_unf", 8'd1, 3'd0, 1'b1, 1'b1);
    step(INC, 8'd0, "flags_sticky", 8'd2, 3'd0, 1'b1, 1'b1);

    // Wrap, dispatch, fetch
    do_reset("reset_before_wrap");
    step(JUMP, 8'd255, "jump255", 8'd255, 3'd0, 1'b0, 1'b0);
    step(INC, 8'd0, "inc_wrap", 8'd0, 3'd0, 1'b0, 1'b0);
    dispatch_addr = 8'h9C;
    step(DISP, 8'd0, "dispatch", 8'h9C, 3'd0, 1'b0, 1'b0);
    step(FETCH, 8'd0, "fetch", 8'd1, 3'd0, 1'b0, 1'b0);

    // Reset with non-empty stack and ovf set
    do_reset("reset_before_mid");
    step(JUMP, 8'd7, "jump7b", 8'd7, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(CALL, targets[i], "call_b", targets[i], 3'(i + 1), 1'b0, 1'b0);
    step(CALL, 8'd70, "call_ovf_b", 8'd70, 3'd4, 1'b1, 1'b0);
    step(RET, 8'd0, "ret1_b", 8'd51, 3'd3, 1'b1, 1'b0);
    step(RET, 8'd0, "ret2_b", 8'd31, 3'd2, 1'b1, 1'b0);
    do_reset("reset_mid_stack");
    step(RET, 8'd0, "ret_after_reset", 8'd1, 3'd0, 1'b0, 1'b1);

    // Reset during a WAIT hold, then first op runs from reset address
    step(JUMP, 8'd5, "jump5c", 8'd5, 3'd0, 1'b0, 1'b1);
    step(WAIT, 8'd0, "wait_hold_c", 8'd5, 3'd0, 1'b0, 1'b1);
    do_reset("reset_mid_wait");
    step(INC, 8'd0, "first_op_after_reset", 8'd1, 3'd0, 1'b0, 1'b0);

    repeat (3) @(negedge CLK);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
